// File: rtl/diag_spi_master_if.sv
// Command, response and SPI pin bundle for the diagnostics SPI master.
// master modport is the initiator core; slave modport is the local command logic plus SPI target.
interface diag_spi_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        done;
    logic        err;
    logic [7:0]  rsp_data;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, spi_miso,
        output cmd_ready, done, err, rsp_data, spi_clk, spi_mosi, spi_cs
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, spi_miso,
        input  cmd_ready, done, err, rsp_data, spi_clk, spi_mosi, spi_cs
    );
endinterface

// File: rtl/diag_spi_master.sv
// SPI mode-0 initiator for diagnostics commands; done lands 1+CLK_DIV*(2N+2) cycles after accept (1 for bad ops).
// cmd_ready only in IDLE, no queueing; a new command waits out the CS_GAP after each done.
module diag_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    diag_spi_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE, S_GAP
    } state_t;

    localparam int            CW       = 16;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [5:0]    nbits_q, nbits_d;
    logic [31:0]   tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          rd_q, rd_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    rsp_q, rsp_d;

    logic [31:0]   frame;
    logic [5:0]    frame_bits;
    logic          op_ok;
    logic          div_end;
    logic [7:0]    rx_shift;

    assign div_end  = (cnt_q == DIV_LAST);
    assign rx_shift = {rx_q[6:0], bus.spi_miso};

    // Frames are left-aligned so the first wire bit is always frame[31].
    always_comb begin
        frame      = 32'h0;
        frame_bits = 6'd0;
        op_ok      = 1'b1;
        case (bus.cmd_op)
            3'd0: begin
                frame      = {8'h01, 24'h0};
                frame_bits = 6'd8;
            end
            3'd1: begin
                frame      = {8'h02, 24'h0};
                frame_bits = 6'd8;
            end
            3'd2: begin
                frame      = {8'h03, bus.cmd_addr, 8'h00};
                frame_bits = 6'd32;
            end
            3'd3: begin
                frame      = {8'h04, bus.cmd_addr, bus.cmd_wdata};
                frame_bits = 6'd32;
            end
            3'd4: begin
                frame      = {8'h05, bus.cmd_wdata, 16'h0};
                frame_bits = 6'd16;
            end
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        nbits_d = nbits_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rsp_d   = rsp_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cnt_d = '0;
                    bit_d = 6'd0;
                    if (op_ok) begin
                        state_d = S_SETUP;
                        cs_d    = 1'b0;
                        mosi_d  = frame[31];
                        tx_d    = frame;
                        nbits_d = frame_bits;
                        rd_d    = (bus.cmd_op == 3'd2);
                        rx_d    = 8'h00;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (div_end) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                    sclk_d  = 1'b1;
                    rx_d    = rx_shift;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_XFER: begin
                if (div_end) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 6'd1;
                        tx_d   = {tx_q[30:0], 1'b0};
                        mosi_d = tx_q[30];
                    end else if (bit_q == nbits_q) begin
                        // Final low half-period has elapsed after the last falling edge.
                        state_d = S_HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = rx_shift;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (div_end) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rd_q) begin
                        rsp_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 6'd0;
            nbits_q <= 6'd0;
            tx_q    <= 32'h0;
            rx_q    <= 8'h00;
            rd_q    <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rsp_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            nbits_q <= nbits_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rsp_data  = rsp_q;
    assign bus.spi_clk   = sclk_q;
    assign bus.spi_mosi  = mosi_q;
    assign bus.spi_cs    = cs_q;

    a_err_with_done : assert property (@(posedge clk) disable iff (!rst_n) err_q |-> done_q);
    a_clk_low_idle  : assert property (@(posedge clk) disable iff (!rst_n) cs_q |-> !sclk_q);
endmodule

// File: tb/tb_diag_spi_master.sv
// Randomized scoreboard bench for diag_spi_master with a behavioural SPI target model.
module tb_diag_spi_master;
    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 8;

    typedef struct {
        logic [31:0] data;
        int          nbits;
    } frame_t;

    typedef struct {
        logic       err;
        logic [7:0] rsp;
        int         edge_n;
    } done_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    frame_t      exp_frame_q[$];
    done_t       done_q[$];
    logic [31:0] miso_q[$];

    int         acc_e     = -1;
    int         busy_end  = -2;
    int         last_done = 0;
    logic [7:0] model_rsp = 8'h00;
    bit         abort     = 1'b0;

    diag_spi_master_if bus();

    diag_spi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Wire image of a command: opcode byte followed by its operands, MSB first.
    task automatic ref_frame(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] wd,
                             output logic [31:0] data, output int nb, output bit ok);
        logic [7:0] bytes[$];
        ok = 1'b1;
        case (op)
            3'd0: bytes = '{8'h01};
            3'd1: bytes = '{8'h02};
            3'd2: bytes = '{8'h03, addr[15:8], addr[7:0], 8'h00};
            3'd3: bytes = '{8'h04, addr[15:8], addr[7:0], wd};
            3'd4: bytes = '{8'h05, wd};
            default: ok = 1'b0;
        endcase
        data = 32'h0;
        nb   = 8 * bytes.size();
        for (int i = 0; i < bytes.size(); i++) data[31 - 8*i -: 8] = bytes[i];
    endtask

    // SPI target model: captures MOSI on rising edges, shifts MISO out on falling edges.
    logic        cs_p = 1'b1, sclk_p = 1'b0, mosi_p = 1'b0;
    int          rise_cnt = 0, fall_cnt = 0, low_cnt = 0;
    logic [31:0] cap = 32'h0, miso_w = 32'h0;
    frame_t      fm;

    always @(negedge clk) begin
        if (cs_p && !bus.spi_cs) begin
            rise_cnt = 0;
            fall_cnt = 0;
            low_cnt  = 0;
            cap      = 32'h0;
            miso_w   = (miso_q.size() > 0) ? miso_q.pop_front() : 32'h0;
            bus.spi_miso = miso_w[31];
        end
        if (!bus.spi_cs) begin
            low_cnt++;
            if (!sclk_p && bus.spi_clk) begin
                chk(bus.spi_mosi == mosi_p, "mosi_stable_at_rise", 32'(bus.spi_mosi), 32'(mosi_p));
                if (rise_cnt < 32) cap[31 - rise_cnt] = bus.spi_mosi;
                rise_cnt++;
            end
            if (sclk_p && !bus.spi_clk) begin
                fall_cnt++;
                if (fall_cnt < 32) bus.spi_miso = miso_w[31 - fall_cnt];
            end
        end else begin
            chk(bus.spi_clk == 1'b0, "spi_clk_low_while_cs_high", 32'(bus.spi_clk), 32'd0);
            if (!cs_p) begin
                if (abort) begin
                    abort = 1'b0;
                end else if (exp_frame_q.size() == 0) begin
                    chk(1'b0, "unexpected_frame", cap, 32'h0);
                end else begin
                    fm = exp_frame_q.pop_front();
                    chk(cap == fm.data, "frame_bits", cap, fm.data);
                    chk(rise_cnt == fm.nbits, "rising_edges", rise_cnt, fm.nbits);
                    chk(low_cnt == CLK_DIV * (2 * fm.nbits + 2), "cs_low_cycles", low_cnt,
                        CLK_DIV * (2 * fm.nbits + 2));
                end
            end
        end
        cs_p   = bus.spi_cs;
        sclk_p = bus.spi_clk;
        mosi_p = bus.spi_mosi;
    end

    // Response monitor: readiness window, done/err pulses, read data and completion cycle.
    done_t dm;
    logic  exp_ready;

    always @(negedge clk) begin
        if (rst_n) begin
            exp_ready = !(cyc >= acc_e && cyc <= busy_end);
            chk(bus.cmd_ready == exp_ready, "cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
            chk(!(bus.err && !bus.done), "err_without_done", 32'(bus.err), 32'd0);
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 32'd1, 32'd0);
                end else begin
                    dm = done_q.pop_front();
                    chk(bus.err == dm.err, "err", 32'(bus.err), 32'(dm.err));
                    chk(bus.rsp_data == dm.rsp, "rsp_data", 32'(bus.rsp_data), 32'(dm.rsp));
                    chk(cyc == dm.edge_n, "done_cycle", cyc, dm.edge_n);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [31:0] miso, input bit keep, input bit scramble, input bit chk_gap);
        logic [31:0] fdat;
        int          nb;
        bit          ok;
        int          n;
        int          e0;
        done_t       d;
        frame_t      f;
        @(posedge clk); #2;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        if (!bus.cmd_ready) begin
            chk(1'b0, "accept_timeout", 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        ref_frame(op, addr, wd, fdat, nb, ok);
        e0 = cyc + 1;
        if (chk_gap) chk(e0 == last_done + CS_GAP + 2, "b2b_accept_cycle", e0, last_done + CS_GAP + 2);
        if (ok && op == 3'd2) model_rsp = miso[7:0];
        d.err    = !ok;
        d.rsp    = model_rsp;
        d.edge_n = e0 + (ok ? CLK_DIV * (2 * nb + 2) : 0);
        acc_e     = e0;
        busy_end  = d.edge_n + CS_GAP;
        last_done = d.edge_n;
        done_q.push_back(d);
        if (ok) begin
            f.data  = fdat;
            f.nbits = nb;
            exp_frame_q.push_back(f);
            miso_q.push_back(miso);
        end
        @(posedge clk); #2;
        if (!keep) bus.cmd_valid = 1'b0;
        if (scramble) begin
            while (cyc < d.edge_n) begin
                bus.cmd_addr  = 16'($urandom);
                bus.cmd_wdata = 8'($urandom);
                bus.cmd_op    = 3'($urandom);
                bus.cmd_valid = 1'($urandom);
                @(posedge clk); #2;
            end
            bus.cmd_valid = 1'b0;
        end
    endtask

    int wn;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_addr  = 16'h0;
        bus.cmd_wdata = 8'h0;
        bus.spi_miso  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({bus.spi_cs, bus.spi_clk, bus.spi_mosi, bus.done, bus.err, bus.rsp_data} == {5'b10000, 8'h00},
            "reset_outputs", {bus.spi_cs, bus.spi_clk, bus.spi_mosi, bus.done, bus.err, bus.rsp_data},
            {5'b10000, 8'h00});
        #1 rst_n = 1'b1;

        repeat (50) begin
            @(negedge clk);
            chk({bus.spi_cs, bus.spi_clk, bus.spi_mosi, bus.done, bus.cmd_ready} == 5'b10001,
                "idle_outputs", {bus.spi_cs, bus.spi_clk, bus.spi_mosi, bus.done, bus.cmd_ready}, 5'b10001);
        end

        issue(3'd2, 16'hE84C, 8'h00, {24'h5A3C96, 8'hA5}, 1'b0, 1'b0, 1'b0);
        issue(3'd3, 16'h8000, 8'h3C, $urandom, 1'b1, 1'b0, 1'b0);
        issue(3'd0, 16'($urandom), 8'($urandom), $urandom, 1'b0, 1'b0, 1'b1);
        issue(3'd6, 16'($urandom), 8'($urandom), $urandom, 1'b0, 1'b0, 1'b0);
        issue(3'd2, 16'($urandom), 8'($urandom), $urandom | 32'h1, 1'b0, 1'b1, 1'b0);

        // Abort a WRITE partway through with an asynchronous reset.
        issue(3'd3, 16'($urandom), 8'($urandom), $urandom, 1'b0, 1'b0, 1'b0);
        wn = 0;
        while (!(!bus.spi_cs && rise_cnt == 13) && wn < 1000) begin
            @(posedge clk);
            wn++;
        end
        chk(rise_cnt == 13, "reach_bit13", rise_cnt, 13);
        #3;
        abort = 1'b1;
        exp_frame_q.delete();
        done_q.delete();
        miso_q.delete();
        acc_e     = -1;
        busy_end  = -2;
        model_rsp = 8'h00;
        rst_n = 1'b0;
        #1;
        chk({bus.spi_cs, bus.spi_clk} == 2'b10, "reset_midframe_pins", {bus.spi_cs, bus.spi_clk}, 2'b10);
        chk(bus.rsp_data == 8'h00, "reset_midframe_rsp", bus.rsp_data, 8'h00);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        issue(3'd4, 16'($urandom), 8'h1F, $urandom, 1'b0, 1'b0, 1'b0);

        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(3'($urandom), 16'($urandom), 8'($urandom), $urandom, 1'b0, 1'b0, 1'b0);
        end

        wn = 0;
        while ((done_q.size() != 0 || exp_frame_q.size() != 0) && wn < 5000) begin
            @(posedge clk);
            wn++;
        end
        chk(done_q.size() == 0 && exp_frame_q.size() == 0, "drain",
            done_q.size() + exp_frame_q.size(), 32'd0);
        repeat (20) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/diag_spi_master.md
Name: diag_spi_master

Overview:
- SPI initiator for the diagnostics command interface: the other end of the diagnostics SPI slave.
- Sits in the bench-side/companion FPGA. Takes single commands from local logic: halt CPU, resume CPU, read RAM byte, write RAM byte, set configuration.
- Serializes each command as one chip-select framed SPI mode-0 transaction, MSB first.
- Returns read data and a completion pulse.

Parameters:
- CLK_DIV, 4: clk cycles per SPI half-period. Must be ≥1.
- CS_GAP, 8: minimum clk cycles spi_cs stays high between frames. Must be ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high when IDLE; a command is accepted on a cycle with cmd_valid&&cmd_ready.
- cmd_op  input  3  0=HALT, 1=RUN, 2=READ, 3=WRITE, 4=SET_CONFIG, 5-7 invalid.
- cmd_addr  input  16  RAM address (READ/WRITE).
- cmd_wdata  input  8  write data (WRITE) or config value (SET_CONFIG).
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  valid with done; 1 = invalid opcode.
- rsp_data  output  8  byte captured during READ; holds until the next READ completes.
- spi_clk  output  1  SPI clock, idle low.
- spi_mosi  output  1  serial out.
- spi_miso  input  1  serial in.
- spi_cs  output  1  active-low chip select.

Behaviour:
- Reset (async, reset=0): state IDLE, spi_cs=1, spi_clk=0, spi_mosi=0, done=0, err=0, rsp_data=8'h00, cmd_ready=1 once reset releases.
- Inputs are captured at acceptance. Later changes on the cmd_* inputs have no effect.
- Wire opcodes and frame contents:
  - HALT: 0x01, 1 byte.
  - RUN: 0x02, 1 byte.
  - READ: 0x03, addr_hi, addr_lo, 0x00 dummy. 4 bytes; MISO is captured during byte 4.
  - WRITE: 0x04, addr_hi, addr_lo, wdata. 4 bytes.
  - SET_CONFIG: 0x05, wdata. 2 bytes.
- States:
  - IDLE: cmd_ready=1. On accept of a valid op, go to SETUP. On accept of an invalid op, go to DONE, err=1, no SPI activity.
  - SETUP: spi_cs=0, spi_mosi=first bit. Stay CLK_DIV cycles, then XFER.
  - XFER: alternate spi_clk every CLK_DIV cycles; N = 8*bytes rising edges.
    - Rising edge: sample spi_miso into shift register.
    - Falling edge: drive next MOSI bit.
    - After the N-th falling edge (spi_clk low), go to HOLD.
  - HOLD: spi_cs=0, spi_clk=0 for CLK_DIV cycles, then spi_cs=1 and go to DONE.
  - DONE: one cycle. done=1. For READ, load rsp_data from the shift register. Then go to GAP.
  - GAP: spi_cs=1 for CS_GAP cycles (counted from the first cycle after the DONE cycle), then IDLE.
- Frame length, spi_cs falling to rising: CLK_DIV*(2N+2) cycles.
- Accept-to-done latency: 1 + CLK_DIV*(2N+2) cycles for valid ops; 1 cycle for invalid ops.
- cmd_ready=0 in every state except IDLE. No queueing: cmd_valid outside IDLE is ignored.
- A second command cannot be accepted until the GAP has elapsed.
- spi_clk stays low whenever spi_cs=1. MOSI is stable across every rising edge.
- Bit counter 6 bits; byte index derived from it. Address is sent big-endian.
- MISO bits sampled during bytes 1-3 of a READ are discarded.
- Reset asserted mid-frame: spi_cs rises and spi_clk falls immediately (async). No done pulse. The partial frame is abandoned and rsp_data becomes 8'h00.
- done and err are registered outputs. err=0 whenever done=0.

Test Plan:
- Reset then idle 50 cycles -> spi_cs=1, spi_clk=0, spi_mosi=0, cmd_ready=1, done=0 throughout.
- CLK_DIV=2, CS_GAP=8, READ addr=16'hE84C, slave returns 8'hA5 in byte 4 -> MOSI bytes 03,E8,4C,00. spi_cs low exactly 132 cycles with 32 rising edges. done at accept+133, err=0, rsp_data=8'hA5.
- WRITE addr=16'h8000 wdata=8'h3C, followed immediately by HALT with cmd_valid held -> MOSI 04,80,00,3C. HALT accepted no earlier than 8 cycles after WRITE done. Second frame is the single byte 01 (cs low 36 cycles).
- cmd_op=6 -> no spi_cs activity. done and err both high 1 cycle after accept. cmd_ready back after CS_GAP.
- Reset pulsed low during bit 13 of a WRITE -> spi_cs=1 and spi_clk=0 in the same cycle. No done pulse. Next SET_CONFIG 8'h1F produces a clean frame 05,1F.
- Change cmd_addr/cmd_wdata every cycle during a READ -> transmitted bytes match values captured at accept.
